id_ex_stage: RTL and testbench

- ID/EX pipeline stage, directly downstream of the register file.
- Captures decoded operands (RD1/RD2), register indices, immediate, PC and control bundle each cycle, and presents them registered to EX.
- Contains load-use hazard detection (stall request plus bubble injection), branch/jump flush, and write-back bypass of operands being written in the same cycle.

---
 rtl/id_ex_stage_pkg.sv | 25 ++
 rtl/id_ex_stage_hazard.sv | 37 +++
 rtl/id_ex_stage.sv | 134 +++++++++++++
 tb/tb_id_ex_stage.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_ex_stage_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg: definitions shared between the ID/EX stage, its hazard unit
// and anything else that needs to read the control bundle.
//
// Control bundle layout (CW_DEF = 8 bits):
//   [7] reg_write  [6] mem_read  [5] mem_write  [4] alu_src  [3:0] alu_op
// A bubble carries BUBBLE_CTRL, so a bubble can never write a register
// or touch memory.
// ---------------------------------------------------------------------------
package cpu_pkg;

    localparam int DW_DEF = 32;
    localparam int AW_DEF = 5;
    localparam int CW_DEF = 8;

    localparam int CTRL_REGW      = 7;
    localparam int CTRL_MEMR      = 6;
    localparam int CTRL_MEMW      = 5;
    localparam int CTRL_ALUSRC    = 4;
    localparam int CTRL_ALUOP_MSB = 3;
    localparam int CTRL_ALUOP_LSB = 0;

    localparam logic [CW_DEF-1:0] BUBBLE_CTRL = '0;

endpackage : cpu_pkg

// File: rtl/id_ex_stage_hazard.sv
// ---------------------------------------------------------------------------
// idex_hazard: combinational load-use hazard detection for the ID/EX stage.
//
// Ports:
//   rst          in   reset; forces stall low while asserted
//   flush        in   branch/jump taken; a flush overrides the stall
//   id_valid     in   ID holds a real instruction
//   id_rs/id_rt  in   ID source indices
//   ex_valid     in   EX holds a real instruction
//   ex_mem_read  in   EX instruction is a load
//   ex_rd        in   EX destination index
//   haz          out  raw load-use hazard
//   stall        out  stall request to PC and IF/ID
// ---------------------------------------------------------------------------
module idex_hazard #(
    parameter int AW = 5
) (
    input  logic          rst,
    input  logic          flush,
    input  logic          id_valid,
    input  logic [AW-1:0] id_rs,
    input  logic [AW-1:0] id_rt,
    input  logic          ex_valid,
    input  logic          ex_mem_read,
    input  logic [AW-1:0] ex_rd,
    output logic          haz,
    output logic          stall
);

    // A load to register 0 produces nothing anybody can depend on.
    assign haz = id_valid && ex_valid && ex_mem_read && (ex_rd != '0) &&
                 ((ex_rd == id_rs) || (ex_rd == id_rt));

    // The flushed ID instruction is discarded, so holding it would be wasted.
    assign stall = haz && !flush && !rst;

endmodule : idex_hazard

// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage: ID/EX pipeline register with load-use hazard detection,
// branch/jump flush and write-back bypass.
//
// Flow control: id_valid qualifies every id_* field in a cycle. stall_o is
// the only back-pressure: while it is high the upstream stages must hold
// PC and IF/ID and present the same instruction again next cycle; this
// stage inserts a bubble instead of loading it. ex_valid qualifies ex_*.
//
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   id_valid, id_rd1, id_rd2        ID instruction valid, RF read data
//   id_rs, id_rt, id_rd             register indices
//   id_imm, id_pc, id_ctrl          immediate, PC+4, control bundle
//   flush                           discard the ID instruction
//   wb_we, wb_addr, wb_data         write-back port (bypassed into operands)
//   stall_o                         combinational stall request
//   ex_valid, ex_op1, ex_op2        registered valid and operands
//   ex_rs, ex_rt, ex_rd             registered indices
//   ex_imm, ex_pc, ex_ctrl          registered immediate, PC, control
//   stall_cnt, flush_cnt            saturating event counters, present
//                                   only when IDEX_PERF_CNT_EN is defined
// ---------------------------------------------------------------------------
module id_ex_stage
    import cpu_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int AW = AW_DEF,
    parameter int CW = CW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          id_valid,
    input  logic [DW-1:0] id_rd1,
    input  logic [DW-1:0] id_rd2,
    input  logic [AW-1:0] id_rs,
    input  logic [AW-1:0] id_rt,
    input  logic [AW-1:0] id_rd,
    input  logic [DW-1:0] id_imm,
    input  logic [DW-1:0] id_pc,
    input  logic [CW-1:0] id_ctrl,
    input  logic          flush,
    input  logic          wb_we,
    input  logic [AW-1:0] wb_addr,
    input  logic [DW-1:0] wb_data,
    output logic          stall_o,
    output logic          ex_valid,
    output logic [DW-1:0] ex_op1,
    output logic [DW-1:0] ex_op2,
    output logic [AW-1:0] ex_rs,
    output logic [AW-1:0] ex_rt,
    output logic [AW-1:0] ex_rd,
    output logic [DW-1:0] ex_imm,
    output logic [DW-1:0] ex_pc,
    output logic [CW-1:0] ex_ctrl
`ifdef IDEX_PERF_CNT_EN
    ,
    output logic [31:0]   stall_cnt,
    output logic [31:0]   flush_cnt
`endif
);

    localparam logic [CW-1:0] BUBBLE = CW'(BUBBLE_CTRL);

    logic haz;
    logic byp1;
    logic byp2;

    idex_hazard #(
        .AW(AW)
    ) u_hazard (
        .rst        (rst),
        .flush      (flush),
        .id_valid   (id_valid),
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .ex_valid   (ex_valid),
        .ex_mem_read(ex_ctrl[CTRL_MEMR]),
        .ex_rd      (ex_rd),
        .haz        (haz),
        .stall      (stall_o)
    );

    // The RF is written at the same edge it is read here, so its read data
    // is stale for the register being written; take the write data instead.
    assign byp1 = wb_we && (wb_addr != '0) && (wb_addr == id_rs);
    assign byp2 = wb_we && (wb_addr != '0) && (wb_addr == id_rt);

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid <= 1'b0;
            ex_op1   <= '0;
            ex_op2   <= '0;
            ex_rs    <= '0;
            ex_rt    <= '0;
            ex_rd    <= '0;
            ex_imm   <= '0;
            ex_pc    <= '0;
            ex_ctrl  <= BUBBLE;
        end else if (flush || haz) begin
            // Bubble: only valid and control are cleared; the data registers
            // are don't-care while ex_valid is low and simply hold.
            ex_valid <= 1'b0;
            ex_ctrl  <= BUBBLE;
        end else begin
            ex_valid <= id_valid;
            ex_op1   <= byp1 ? wb_data : id_rd1;
            ex_op2   <= byp2 ? wb_data : id_rd2;
            ex_rs    <= id_rs;
            ex_rt    <= id_rt;
            ex_rd    <= id_rd;
            ex_imm   <= id_imm;
            ex_pc    <= id_pc;
            ex_ctrl  <= id_valid ? id_ctrl : BUBBLE;
        end
    end

`ifdef IDEX_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_o && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
            if (flush && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + 32'd1;
            end
        end
    end
`endif

endmodule : id_ex_stage

// File: tb/tb_id_ex_stage.sv
// ---------------------------------------------------------------------------
// tb_id_ex_stage: directed plus randomized bench for id_ex_stage.
// A reference model predicts the EX bundle after every edge and queues it;
// a compare process pops and checks it at every falling edge, together with
// the combinational stall. Directed steps add literal expectations.
// Define IDEX_PERF_CNT_EN to also check the event counters.
// ---------------------------------------------------------------------------
module tb_id_ex_stage;

    typedef struct packed {
        logic        valid;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [7:0]  ctrl;
    } ex_t;

    localparam int W = $bits(ex_t);

    // ---------------- clock / reset / DUT signals ----------------
    logic        clk;
    logic        rst;
    logic        id_valid;
    logic [31:0] id_rd1, id_rd2, id_imm, id_pc, wb_data;
    logic [4:0]  id_rs, id_rt, id_rd, wb_addr;
    logic [7:0]  id_ctrl;
    logic        flush, wb_we;
    logic        stall_o, ex_valid;
    logic [31:0] ex_op1, ex_op2, ex_imm, ex_pc;
    logic [4:0]  ex_rs, ex_rt, ex_rd;
    logic [7:0]  ex_ctrl;
`ifdef IDEX_PERF_CNT_EN
    logic [31:0] stall_cnt, flush_cnt;
`endif

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    id_ex_stage dut (
        .clk      (clk),
        .rst      (rst),
        .id_valid (id_valid),
        .id_rd1   (id_rd1),
        .id_rd2   (id_rd2),
        .id_rs    (id_rs),
        .id_rt    (id_rt),
        .id_rd    (id_rd),
        .id_imm   (id_imm),
        .id_pc    (id_pc),
        .id_ctrl  (id_ctrl),
        .flush    (flush),
        .wb_we    (wb_we),
        .wb_addr  (wb_addr),
        .wb_data  (wb_data),
        .stall_o  (stall_o),
        .ex_valid (ex_valid),
        .ex_op1   (ex_op1),
        .ex_op2   (ex_op2),
        .ex_rs    (ex_rs),
        .ex_rt    (ex_rt),
        .ex_rd    (ex_rd),
        .ex_imm   (ex_imm),
        .ex_pc    (ex_pc),
        .ex_ctrl  (ex_ctrl)
`ifdef IDEX_PERF_CNT_EN
        ,
        .stall_cnt(stall_cnt),
        .flush_cnt(flush_cnt)
`endif
    );

    // ---------------- check bookkeeping ----------------
    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // m is what EX must hold after the most recent edge.
    ex_t         m = '0;
    logic [31:0] m_stall_cnt = 0;
    logic [31:0] m_flush_cnt = 0;
    logic [W-1:0] exp_q[$];

    // A load in EX whose (nonzero) destination feeds the ID instruction.
    function automatic logic model_load_use();
        return id_valid && m.valid && m.ctrl[6] && (m.rd != 0) &&
               ((m.rd == id_rs) || (m.rd == id_rt));
    endfunction

    function automatic logic model_stall();
        return model_load_use() && !flush && !rst;
    endfunction

    always @(posedge clk) begin : model
        logic lu;
        logic st;
        lu = model_load_use();
        st = model_stall();
        if (!rst) begin
            if (st && m_stall_cnt != 32'hFFFF_FFFF) m_stall_cnt = m_stall_cnt + 1;
            if (flush && m_flush_cnt != 32'hFFFF_FFFF) m_flush_cnt = m_flush_cnt + 1;
        end else begin
            m_stall_cnt = 0;
            m_flush_cnt = 0;
        end
        if (rst) begin
            m = '0;
        end else if (flush || lu) begin
            m.valid = 1'b0;
            m.ctrl  = 8'h00;
        end else begin
            m.valid = id_valid;
            m.op1   = (wb_we && wb_addr != 0 && wb_addr == id_rs) ? wb_data : id_rd1;
            m.op2   = (wb_we && wb_addr != 0 && wb_addr == id_rt) ? wb_data : id_rd2;
            m.rs    = id_rs;
            m.rt    = id_rt;
            m.rd    = id_rd;
            m.imm   = id_imm;
            m.pc    = id_pc;
            m.ctrl  = id_valid ? id_ctrl : 8'h00;
        end
        exp_q.push_back(W'(m));
    end

    // ---------------- scoreboard / compare ----------------
    always @(negedge clk) begin : compare
        ex_t e;
        if (exp_q.size() > 0) begin
            e = ex_t'(exp_q.pop_front());
            chk("sb_ex_valid", 64'(ex_valid), 64'(e.valid));
            chk("sb_ex_ctrl",  64'(ex_ctrl),  64'(e.ctrl));
            // Data fields only matter while EX holds a real instruction.
            if (e.valid) begin
                chk("sb_ex_op1", 64'(ex_op1), 64'(e.op1));
                chk("sb_ex_op2", 64'(ex_op2), 64'(e.op2));
                chk("sb_ex_idx", 64'({ex_rs, ex_rt, ex_rd}), 64'({e.rs, e.rt, e.rd}));
                chk("sb_ex_imm", 64'(ex_imm), 64'(e.imm));
                chk("sb_ex_pc",  64'(ex_pc),  64'(e.pc));
            end
            chk("sb_stall_o", 64'(stall_o), 64'(model_stall()));
`ifdef IDEX_PERF_CNT_EN
            chk("sb_stall_cnt", 64'(stall_cnt), 64'(m_stall_cnt));
            chk("sb_flush_cnt", 64'(flush_cnt), 64'(m_flush_cnt));
`endif
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                            input logic [4:0] rd, input logic [31:0] rd1,
                            input logic [31:0] rd2, input logic [7:0] ctrl);
        id_valid = v;
        id_rs    = rs;
        id_rt    = rt;
        id_rd    = rd;
        id_rd1   = rd1;
        id_rd2   = rd2;
        id_ctrl  = ctrl;
        id_imm   = $urandom;
        id_pc    = $urandom;
    endtask

    task automatic drive_wb(input logic we, input logic [4:0] addr, input logic [31:0] data);
        wb_we   = we;
        wb_addr = addr;
        wb_data = data;
    endtask

    task automatic drive_random();
        rst   = ($urandom_range(0, 49) == 0);
        flush = ($urandom_range(0, 7) == 0);
        drive_id($urandom_range(0, 3) != 0, 5'($urandom_range(0, 3)),
                 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 $urandom, $urandom,
                 {($urandom_range(0, 1) == 1) ? 8'h40 : 8'h00} | 8'($urandom));
        drive_wb($urandom_range(0, 1) == 1, 5'($urandom_range(0, 3)), $urandom);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst   = 1'b1;
        flush = 1'b0;
        drive_id(1'b1, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 8'hF3);
        drive_wb(1'b0, 5'd0, 32'h0);

        // Reset with a valid instruction on the inputs.
        @(negedge clk);
        chk("rst_stall_o", 64'(stall_o), 64'h0);
        tick();
        chk("rst_ex_valid", 64'(ex_valid), 64'h0);
        chk("rst_ex_ctrl",  64'(ex_ctrl),  64'h00);
        chk("rst_ex_op1",   64'(ex_op1),   64'h0);
        rst = 1'b0;

        // Plain pass-through.
        drive_id(1'b1, 5'd1, 5'd2, 5'd5, 32'h1234, 32'hABCD, 8'h82);
        tick();
        chk("pass_ex_op1",   64'(ex_op1),   64'h1234);
        chk("pass_ex_op2",   64'(ex_op2),   64'hABCD);
        chk("pass_ex_ctrl",  64'(ex_ctrl),  64'h82);
        chk("pass_ex_rd",    64'(ex_rd),    64'h5);
        chk("pass_ex_valid", 64'(ex_valid), 64'h1);

        // Load-use: lw r8 in EX, dependent instruction in ID.
        drive_id(1'b1, 5'd1, 5'd2, 5'd8, 32'h0, 32'h0, 8'hC0);
        tick();
        drive_id(1'b1, 5'd8, 5'd2, 5'd9, 32'h111, 32'h222, 8'h82);
        @(negedge clk);
        chk("lu_stall_1", 64'(stall_o), 64'h1);
        tick();
        chk("lu_bubble_ctrl",  64'(ex_ctrl),  64'h00);
        chk("lu_bubble_valid", 64'(ex_valid), 64'h0);
        @(negedge clk);
        chk("lu_stall_2", 64'(stall_o), 64'h0);
        tick();
        chk("lu_load_ctrl",  64'(ex_ctrl),  64'h82);
        chk("lu_load_valid", 64'(ex_valid), 64'h1);
        chk("lu_load_op1",   64'(ex_op1),   64'h111);

        // Write-back bypass, then index 0 which must not bypass.
        drive_wb(1'b1, 5'd3, 32'hDEADBEEF);
        drive_id(1'b1, 5'd3, 5'd2, 5'd4, 32'h0, 32'h7, 8'h82);
        tick();
        chk("byp_ex_op1", 64'(ex_op1), 64'hDEADBEEF);
        chk("byp_ex_op2", 64'(ex_op2), 64'h7);
        drive_wb(1'b1, 5'd0, 32'hDEADBEEF);
        drive_id(1'b1, 5'd0, 5'd2, 5'd4, 32'h55, 32'h7, 8'h82);
        tick();
        chk("byp0_ex_op1", 64'(ex_op1), 64'h55);
        drive_wb(1'b0, 5'd0, 32'h0);

        // Flush together with a load-use condition: single bubble, no stall.
        drive_id(1'b1, 5'd1, 5'd2, 5'd8, 32'h0, 32'h0, 8'hC0);
        tick();
        drive_id(1'b1, 5'd8, 5'd2, 5'd9, 32'h333, 32'h444, 8'h82);
        flush = 1'b1;
        @(negedge clk);
        chk("fh_stall", 64'(stall_o), 64'h0);
        tick();
        chk("fh_bubble_valid", 64'(ex_valid), 64'h0);
        flush = 1'b0;
        @(negedge clk);
        chk("fh_stall_after", 64'(stall_o), 64'h0);
        tick();
        chk("fh_reload_valid", 64'(ex_valid), 64'h1);
        chk("fh_reload_ctrl",  64'(ex_ctrl),  64'h82);
`ifdef IDEX_PERF_CNT_EN
        chk("perf_stall_cnt", 64'(stall_cnt), 64'h1);
        chk("perf_flush_cnt", 64'(flush_cnt), 64'h1);
`endif

        // Randomized traffic against the model.
        for (int i = 0; i < 500; i++) begin
            drive_random();
            tick();
        end
        rst = 1'b0;
        flush = 1'b0;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_id_ex_stage
